load_use_scoreboard: RTL and testbench
======================================

# load_use_scoreboard

- Parametrised hazard unit for the in-order pipeline; sits beside the ID stage.
- Tracks outstanding load destinations in a per-register countdown scoreboard, so multi-cycle memory latency is handled without a hard-coded single bubble.
- Stalls PC, IF/ID and instruction-write while a source operand is pending, and injects a bubble into ID/EX.
- Also performs taken-branch flush and keeps a saturating stall-cycle counter.

## Interface
Parameters:
- REG_ADDR_W, 4: register-address width; NREGS = 2**REG_ADDR_W.
- LOAD_LAT, 1: cycles a dependent instruction must wait after its load leaves ID (legal 1..7).
- CNT_W, 16: width of the stall performance counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rn1, id_rn2  in  REG_ADDR_W  ID source registers.
- id_rn1_used, id_rn2_used  in  1  source actually read by the instruction.
- id_is_load  in  1  ID instruction is a load.
- id_rd  in  REG_ADDR_W  ID destination register.
- branch_taken  in  1  EX resolved a taken branch this cycle.
- pc_write  out  1  PC update enable.
- ifid_write  out  1  IF/ID register write enable.
- en_iw  out  1  instruction-word write enable.
- id_ex_bubble  out  1  force ID/EX control signals to NOP.
- if_id_flush  out  1  load NOP into IF/ID.
- stall_cnt  out  CNT_W  saturating count of load-use stall cycles.

## Operation
- Scoreboard: one counter per register, width 3, all 0 at reset.
- hazard = id_valid & ((id_rn1_used & cnt[id_rn1]!=0) | (id_rn2_used & cnt[id_rn2]!=0)).
- issue = id_valid & ~hazard & ~branch_taken.
- Priority is branch_taken > hazard > normal.
- branch_taken: pc_write=1, ifid_write=1, en_iw=1, if_id_flush=1, id_ex_bubble=1. The wrong-path ID instruction does not issue and does not touch the scoreboard.
- hazard (no branch): pc_write=0, ifid_write=0, en_iw=0, id_ex_bubble=1, if_id_flush=0.
- Normal: pc_write=1, ifid_write=1, en_iw=1, id_ex_bubble=0, if_id_flush=0.
- Each rising edge, every nonzero counter decrements by 1.
- On an edge with issue & id_is_load, cnt[id_rd] is loaded with LOAD_LAT. This load overrides the decrement of the same entry.
- Non-load issues never modify the scoreboard. A later ALU write to a pending register does not cancel the pending load.
- stall_cnt increments on each edge where hazard & ~branch_taken, and saturates at all-ones.
- A source with its _used bit low never causes a hazard, whatever its register number.

## Timing
- All control outputs are combinational from registered scoreboard state and current inputs; there is no added latency.
- Dependency latency: a load issuing on edge E stalls a dependent in ID for exactly LOAD_LAT cycles. The dependent issues on edge E+LOAD_LAT+1.
- With LOAD_LAT=1 this gives the classic single bubble.
- Back-to-back loads to different registers: each counter runs independently, and the stall lasts until the last needed source clears.
- A dependent arriving partway through a countdown stalls only for the remaining count.
- Reset values (rst_n low, asynchronous): all counters 0, stall_cnt 0. Outputs are then pc_write=1, ifid_write=1, en_iw=1, id_ex_bubble=0, if_id_flush=0, given branch_taken=0.
- Reset asserted mid-countdown clears pending entries immediately.
- id_valid=0 forces hazard=0 and issue=0.

## Configuration
- HAZ_R0_ZERO_EN defined: register 0 is hard-wired zero.
  - Loads with id_rd==0 never set the scoreboard.
  - Sources equal to 0 never cause a hazard.
  - cnt[0] is constant 0.
- HAZ_R0_ZERO_EN undefined: register 0 is treated like every other register.

## Test plan
- Reset-release check, with all inputs low: assert then release rst_n → pc_write=1, ifid_write=1, en_iw=1, id_ex_bubble=0, stall_cnt=0.
- Single-bubble load-use, LOAD_LAT=1:
  - Stimulus: load rd=5 issues, next ID reads rn1=5 used → exactly 1 cycle of pc_write=0 / id_ex_bubble=1.
  - Response: dependent issues next edge, stall_cnt=1.
- Long latency, LOAD_LAT=3, same sequence → 3 stall cycles, stall_cnt=3.
- Independent dependent: rn2=5 with id_rn2_used=0 → 0 stall cycles.
- Branch during stall: branch_taken=1 while a hazard is pending → if_id_flush=1, pc_write=1, stall_cnt unchanged, no scoreboard update from the flushed load.
- R0 and overflow checks:
  - With HAZ_R0_ZERO_EN, load rd=0 followed by a rn1=0 reader → no stall.
  - Without HAZ_R0_ZERO_EN → 1-cycle stall.
  - Forced 2**CNT_W+5 stall cycles → stall_cnt holds at all-ones.

Source files
------------

// File: rtl/load_use_scoreboard.sv
// load_use_scoreboard: load-use hazard unit with per-register countdown scoreboard, branch flush and saturating stall counter.
// Define HAZ_R0_ZERO_EN to hard-wire register 0 as zero (never pending, never a hazard).
module load_use_scoreboard #(
  parameter int REG_ADDR_W = 4,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rn1,
  input  logic [REG_ADDR_W-1:0] id_rn2,
  input  logic                  id_rn1_used,
  input  logic                  id_rn2_used,
  input  logic                  id_is_load,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  branch_taken,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  en_iw,
  output logic                  id_ex_bubble,
  output logic                  if_id_flush,
  output logic [CNT_W-1:0]      stall_cnt
);
  localparam int NREGS = 2**REG_ADDR_W;
`ifdef HAZ_R0_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif
  logic [2:0] cnt [NREGS];
  logic hazard, issue, set_en;
  assign hazard = id_valid & ((id_rn1_used & (cnt[id_rn1] != 3'd0)) | (id_rn2_used & (cnt[id_rn2] != 3'd0)));
  assign issue = id_valid & ~hazard & ~branch_taken;
  // never setting entry 0 keeps it constant zero, which also removes r0 hazards
  assign set_en = issue & id_is_load & ~(R0_ZERO & (id_rd == '0));
  assign pc_write = branch_taken | ~hazard;
  assign ifid_write = branch_taken | ~hazard;
  assign en_iw = branch_taken | ~hazard;
  assign id_ex_bubble = branch_taken | hazard;
  assign if_id_flush = branch_taken;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) cnt[i] <= 3'd0;
      stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++)
        cnt[i] <= (set_en && id_rd == REG_ADDR_W'(i)) ? 3'(LOAD_LAT) : cnt[i] - {2'b00, |cnt[i]};
      if (hazard && !branch_taken && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_load_use_scoreboard.sv
// tb_load_use_scoreboard: directed checks of two scoreboards (LOAD_LAT=1/CNT_W=16 and LOAD_LAT=3/CNT_W=3) on shared stimulus.
module tb_load_use_scoreboard;
`ifdef HAZ_R0_ZERO_EN
  localparam bit R0Z = 1'b1;
`else
  localparam bit R0Z = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n;
  logic id_valid, id_rn1_used, id_rn2_used, id_is_load, branch_taken;
  logic [3:0] id_rn1, id_rn2, id_rd;
  logic pw1, iw1, en1, bb1, fl1, pw3, iw3, en3, bb3, fl3;
  logic [15:0] sc1;
  logic [2:0] sc3;
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  load_use_scoreboard #(.REG_ADDR_W(4), .LOAD_LAT(1), .CNT_W(16)) d1 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rn1(id_rn1), .id_rn2(id_rn2),
    .id_rn1_used(id_rn1_used), .id_rn2_used(id_rn2_used), .id_is_load(id_is_load), .id_rd(id_rd),
    .branch_taken(branch_taken), .pc_write(pw1), .ifid_write(iw1), .en_iw(en1),
    .id_ex_bubble(bb1), .if_id_flush(fl1), .stall_cnt(sc1));
  load_use_scoreboard #(.REG_ADDR_W(4), .LOAD_LAT(3), .CNT_W(3)) d3 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rn1(id_rn1), .id_rn2(id_rn2),
    .id_rn1_used(id_rn1_used), .id_rn2_used(id_rn2_used), .id_is_load(id_is_load), .id_rd(id_rd),
    .branch_taken(branch_taken), .pc_write(pw3), .ifid_write(iw3), .en_iw(en3),
    .id_ex_bubble(bb3), .if_id_flush(fl3), .stall_cnt(sc3));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic set_id(input logic v, input logic [3:0] r1, input logic u1, input logic [3:0] r2,
                        input logic u2, input logic ld, input logic [3:0] rd);
    id_valid = v; id_rn1 = r1; id_rn1_used = u1; id_rn2 = r2; id_rn2_used = u2;
    id_is_load = ld; id_rd = rd;
    #1;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst_n = 1'b0;
    branch_taken = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0);
    #11;
    chk("rst_pw", pw1, 1);
    chk("rst_bb", bb1, 0);
    rst_n = 1'b1;
    tick();
    chk("rel_pw", pw1, 1);
    chk("rel_iw", iw1, 1);
    chk("rel_en", en1, 1);
    chk("rel_bb", bb1, 0);
    chk("rel_fl", fl1, 0);
    chk("rel_sc1", sc1, 0);
    chk("rel_sc3", sc3, 0);
    set_id(1, 0, 0, 0, 0, 1, 5);
    chk("ld_issue_pw", pw1, 1);
    tick();
    set_id(1, 5, 1, 0, 0, 0, 7);
    chk("lu1_pw", pw1, 0);
    chk("lu1_bb", bb1, 1);
    chk("lu1_iw", iw1, 0);
    chk("lu1_en", en1, 0);
    chk("lu3_pw_c1", pw3, 0);
    tick();
    chk("lu1_pw_after", pw1, 1);
    chk("lu1_bb_after", bb1, 0);
    chk("lu1_sc", sc1, 1);
    chk("lu3_pw_c2", pw3, 0);
    tick();
    chk("lu3_pw_c3", pw3, 0);
    chk("lu3_bb_c3", bb3, 1);
    tick();
    chk("lu3_pw_done", pw3, 1);
    chk("lu3_bb_done", bb3, 0);
    chk("lu3_sc", sc3, 3);
    chk("lu1_sc_hold", sc1, 1);
    set_id(1, 0, 0, 0, 0, 1, 5);
    tick();
    set_id(1, 0, 0, 5, 0, 0, 7);
    chk("unused_pw3", pw3, 1);
    chk("unused_bb3", bb3, 0);
    tick();
    chk("unused_sc3", sc3, 3);
    set_id(0, 5, 1, 5, 1, 0, 7);
    chk("invalid_pw3", pw3, 1);
    tick();
    set_id(1, 5, 1, 0, 0, 1, 6);
    branch_taken = 1'b1;
    #1;
    chk("br_fl3", fl3, 1);
    chk("br_pw3", pw3, 1);
    chk("br_iw3", iw3, 1);
    chk("br_bb3", bb3, 1);
    chk("br_fl1", fl1, 1);
    chk("br_bb1", bb1, 1);
    tick();
    branch_taken = 1'b0;
    #1;
    chk("br_sc3", sc3, 3);
    chk("br_fl_clear", fl3, 0);
    set_id(1, 6, 1, 0, 0, 0, 7);
    chk("br_noset_pw3", pw3, 1);
    chk("br_noset_pw1", pw1, 1);
    tick();
    set_id(1, 0, 0, 0, 0, 1, 0);
    tick();
    set_id(1, 0, 1, 0, 0, 0, 7);
    chk("r0_pw1", pw1, R0Z ? 1 : 0);
    tick();
    chk("r0_sc1", sc1, R0Z ? 1 : 2);
    set_id(0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    tick();
    chk("r0_sc3", sc3, R0Z ? 3 : 4);
    for (int p = 0; p < 5; p++) begin
      set_id(1, 0, 0, 0, 0, 1, 5);
      tick();
      set_id(1, 5, 1, 0, 0, 0, 7);
      for (int c = 0; c < 4; c++) tick();
    end
    chk("sat_sc3", sc3, 7);
    chk("sat_sc1", sc1, R0Z ? 6 : 7);
    set_id(1, 0, 0, 0, 0, 1, 5);
    tick();
    set_id(1, 5, 1, 0, 0, 0, 7);
    chk("sat_pw3", pw3, 0);
    tick();
    chk("sat_hold", sc3, 7);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pw3", pw3, 1);
    chk("mid_rst_sc3", sc3, 0);
    chk("mid_rst_sc1", sc1, 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_pw3", pw3, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
